// File: rtl/tetris_move_dispatcher_if.sv
// Handshake bundle between the controller input stage, the move dispatcher and the game FSM.
// The master side drives frame ticks, button codes and ready; the slave side returns the command stream.
interface tetris_move_dispatcher_if;
  logic       frame_tick;
  logic [3:0] button_code;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       overflow;
  logic [2:0] fifo_count;

  modport master (
    output frame_tick, button_code, cmd_ready,
    input  cmd_valid, cmd, overflow, fifo_count
  );

  modport slave (
    input  frame_tick, button_code, cmd_ready,
    output cmd_valid, cmd, overflow, fifo_count
  );
endinterface

// File: rtl/tetris_move_dispatcher.sv
// Converts per-frame button codes into game commands with delayed auto-shift on Left/Right/Down,
// and queues them in a small FIFO that the game FSM drains through a valid/ready handshake.
module tetris_move_dispatcher #(
  parameter int unsigned DAS_FRAMES = 16,
  parameter int unsigned ARR_FRAMES = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   reset,
  tetris_move_dispatcher_if.slave bus
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned MAX_FR = (DAS_FRAMES > ARR_FRAMES) ? DAS_FRAMES : ARR_FRAMES;
  localparam int unsigned RPT_W  = $clog2(MAX_FR + 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_e;

  state_e             state, state_nxt;
  logic [3:0]         prev_code, prev_nxt;
  logic [RPT_W-1:0]   rpt_cnt, rpt_nxt, rpt_inc_c;
  logic [3:0]         code_c;
  logic               push_c;
  logic [2:0]         push_cmd_c;

  logic [2:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic               cmd_valid_q, overflow_q;
  logic [2:0]         cmd_q, head_nxt;
  logic               pop_c, do_push_c, drop_c;

  // Button code to game command: A, B, Select, Start, Up, Down, Left, Right
  function automatic logic [2:0] map_cmd(input logic [3:0] c);
    case (c)
      4'd1:    return 3'd0;
      4'd2:    return 3'd1;
      4'd3:    return 3'd7;
      4'd4:    return 3'd6;
      4'd5:    return 3'd5;
      4'd6:    return 3'd4;
      4'd7:    return 3'd2;
      4'd8:    return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prev_code <= 4'd0;
      rpt_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      prev_code <= prev_nxt;
      rpt_cnt   <= rpt_nxt;
    end
  end

  // Press / DAS / repeat decisions, evaluated only on frame ticks
  always_comb begin
    state_nxt  = state;
    prev_nxt   = prev_code;
    rpt_nxt    = rpt_cnt;
    push_c     = 1'b0;
    code_c     = ((bus.button_code >= 4'd1) && (bus.button_code <= 4'd8)) ? bus.button_code : 4'd0;
    push_cmd_c = map_cmd(code_c);
    rpt_inc_c  = rpt_cnt + RPT_W'(1);
    if (bus.frame_tick) begin
      prev_nxt = code_c;
      if (code_c == 4'd0) begin
        state_nxt = IDLE;
        rpt_nxt   = '0;
      end else if (code_c != prev_code) begin
        push_c    = 1'b1;
        rpt_nxt   = '0;
        state_nxt = (code_c >= 4'd6) ? DELAY : IDLE;
      end else begin
        case (state)
          IDLE: ;
          DELAY: begin
            if (rpt_inc_c == RPT_W'(DAS_FRAMES)) begin
              push_c    = 1'b1;
              rpt_nxt   = '0;
              state_nxt = REPEAT;
            end else begin
              rpt_nxt = rpt_inc_c;
            end
          end
          REPEAT: begin
            if (rpt_inc_c == RPT_W'(ARR_FRAMES)) begin
              push_c  = 1'b1;
              rpt_nxt = '0;
            end else begin
              rpt_nxt = rpt_inc_c;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // FIFO bookkeeping; the head is pre-computed so cmd comes straight from a flop
  always_comb begin
    pop_c     = cmd_valid_q & bus.cmd_ready;
    do_push_c = push_c & ((count < CNT_W'(FIFO_DEPTH)) | pop_c);
    drop_c    = push_c & ~do_push_c;
    count_nxt = count + CNT_W'(do_push_c) - CNT_W'(pop_c);
    wr_nxt    = do_push_c ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_nxt    = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
    head_nxt  = cmd_q;
    if (count_nxt != '0) begin
      if (do_push_c && (wr_ptr == rd_nxt)) head_nxt = push_cmd_c;
      else                                  head_nxt = mem[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push_c) mem[wr_ptr] <= push_cmd_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= 3'd0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr      <= wr_nxt;
      rd_ptr      <= rd_nxt;
      count       <= count_nxt;
      cmd_valid_q <= (count_nxt != '0);
      cmd_q       <= head_nxt;
      overflow_q  <= overflow_q | drop_c;
    end
  end

  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd        = cmd_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = 3'(count);

endmodule
